step_seq_fsm: RTL

STEP_SEQ_FSM -- requirements
Module: step_seq_fsm

---
 rtl/step_seq_fsm.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/step_seq_fsm.sv
// -----------------------------------------------------------------------------
// step_seq_fsm
//
// Purpose:
//   This is a tick-paced step sequencer. A free-running divider produces a
//   one-clk "tick" every DIV_MAX+1 clocks. All state changes and count updates
//   happen only on tick cycles.
//   - The asynchronous "go" request is synchronised by two flops and then
//     sampled on ticks to give go_f.
//   - A two-state FSM (IDLE/RUN) steps the counter once when RUN is entered.
//   - While in RUN, it steps once per tick if rpt is high.
//   - Up/down steps either wrap or saturate. Any step that wraps or clamps
//     raises a one-clk limit pulse.
//
// Configuration:
//   STEP_SEQ_DEBOUNCE_EN (macro)
//     Defined:   go_f only changes after go_s has differed from go_f on
//                DEB_TICKS consecutive ticks.
//     Undefined: go_f is go_s as sampled on each tick.
//
// Parameters:
//   DIV_MAX   : tick period is DIV_MAX+1 clk cycles
//   CNT_W     : counter width
//   STEP      : amount added or subtracted per step (1 .. 2^CNT_W-1)
//   SAT       : 0 = wrap modulo 2^CNT_W, 1 = saturate at 0 / 2^CNT_W-1
//   DEB_TICKS : debounce stability length in ticks (1..15)
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   go    in   asynchronous request level
//   dir   in   count direction (0 up, 1 down), used on ticks only
//   rpt   in   repeat mode: step every tick while RUN and go_f held
//   count out  current count value (registered)
//   busy  out  high while the FSM is in RUN (registered); this is the FSM
//              state as seen from outside
//   done  out  combinational pulse on the tick that leaves RUN
//   limit out  one-clk pulse, registered with count, on a wrap or clamp
//
// Handshake:
//   There is no valid/ready pair.
//   - go is a level request.
//   - done is a single-clk completion pulse. It is asserted during the tick
//     cycle in which RUN exits because go_f has dropped.
//   - A reset never produces done.
// -----------------------------------------------------------------------------
module step_seq_fsm #(
  parameter int DIV_MAX   = 599999,
  parameter int CNT_W     = 4,
  parameter int STEP      = 1,
  parameter int SAT       = 0,
  parameter int DEB_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             dir,
  input  logic             rpt,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             limit
);

  // ---------------------------------------------------------------------------
  // Tick divider: counts 0..DIV_MAX, tick while at DIV_MAX
  // ---------------------------------------------------------------------------
  localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_MAX[DIV_W-1:0];

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // go synchroniser
  // ---------------------------------------------------------------------------
  logic go_m;
  logic go_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_m <= 1'b0;
      go_s <= 1'b0;
    end else begin
      go_m <= go;
      go_s <= go_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Filtered request.
  // go_f_nxt is the value go_f takes at the end of this cycle. The FSM
  // decides on go_f_nxt rather than go_f, so the tick that samples (or
  // debounce-qualifies) a new request value is also the tick that acts on it.
  // ---------------------------------------------------------------------------
  logic go_f;
  logic go_f_nxt;

`ifdef STEP_SEQ_DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS - 1);

  // deb_cnt counts consecutive mismatching ticks minus one. Any tick where
  // go_s agrees with go_f restarts the run from zero.
  logic [3:0] deb_cnt;
  logic [3:0] deb_cnt_nxt;

  always_comb begin
    go_f_nxt    = go_f;
    deb_cnt_nxt = deb_cnt;
    if (tick) begin
      if (go_s != go_f) begin
        if (deb_cnt == DEB_LAST) begin
          go_f_nxt    = go_s;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 4'd1;
        end
      end else begin
        deb_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt_nxt;
    end
  end
`else
  always_comb begin
    go_f_nxt = go_f;
    if (tick) begin
      go_f_nxt = go_s;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_f <= 1'b0;
    end else begin
      go_f <= go_f_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Step arithmetic.
  // The add and subtract are done one bit wider than the counter. The extra
  // MSB is the carry for an up-step, or the borrow for a down-step.
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W:0]   STEP_V  = STEP[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
  localparam bit               SAT_EN  = (SAT != 0);

  logic [CNT_W:0]   up_sum;
  logic [CNT_W:0]   dn_diff;
  logic [CNT_W-1:0] step_val;
  logic             step_lim;

  assign up_sum  = {1'b0, count} + STEP_V;
  assign dn_diff = {1'b0, count} - STEP_V;

  always_comb begin
    step_val = up_sum[CNT_W-1:0];
    step_lim = 1'b0;
    if (dir) begin
      step_lim = dn_diff[CNT_W];
      if (dn_diff[CNT_W] && SAT_EN) begin
        step_val = '0;
      end else begin
        step_val = dn_diff[CNT_W-1:0];
      end
    end else begin
      step_lim = up_sum[CNT_W];
      if (up_sum[CNT_W] && SAT_EN) begin
        step_val = CNT_TOP;
      end else begin
        step_val = up_sum[CNT_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   step_en;

  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    done      = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (go_f_nxt) begin
            state_nxt = RUN;
            step_en   = 1'b1;
          end
        end
        RUN: begin
          if (go_f_nxt) begin
            step_en = rpt;
          end else begin
            state_nxt = IDLE;
            done      = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
      limit <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      limit <= step_en & step_lim;
      if (step_en) begin
        count <= step_val;
      end
    end
  end

endmodule
